oclib_bc_async_1b_sink: RTL and testbench
=========================================

// Module: oclib_bc_async_1b_sink
// PURPOSE
// - Receiving end of the serial async byte channel (bc_async_1b_s in, bc_async_1b_fb_s ack out).
// - Source toggles data[0] to send a 0 bit and data[1] to send a 1 bit.
// - Block synchronizes both wires, decodes bits LSB-first into bytes and acks each bit with data[0]^data[1].
// - Presents each byte on a synchronous bc_8b_s ready/valid port. Sits at chip/block boundaries, feeding CSR byte parsers.
// PARAMETERS
// - SyncCycles     default 3     synchronizer depth on bcIn.data, range 2..8
// - TimeoutCycles  default 1024  idle cycles before a partial byte is discarded (macro-gated feature only)
// PORTS
// - clock      input   1  single clock for all logic
// - reset      input   1  synchronous, active-high
// - bcIn       input   2  bc_async_1b_s: data[1:0] from remote source, asynchronous to clock
// - bcInAck    output  1  bc_async_1b_fb_s: ack to remote source, driven from a flop
// - bcOut      output  9  bc_8b_s: {data[7:0], valid}
// - bcOutReady input   1  bc_8b_fb_s.ready from downstream
// - error      output  1  sticky protocol error: both data wires toggled in one decode cycle
// BEHAVIOUR
// - Reset values: bcInAck=0, bcOut.valid=0, bcOut.data=0, error=0, bitCount=0, shift=0, dataLast=2'b00.
// - The source idles with data=2'b00 after its own reset.
// - Reset mid-byte discards partial bits. Source and sink are reset together.
// - Sync: bcIn.data passes through SyncCycles flops to dataSync. No logic is applied before the first flop.
// - Decode (each cycle): toggle = dataSync ^ dataLast.
// - toggle==2'b00: no action.
// - toggle==2'b01 (bit 0) or 2'b10 (bit 1): a bit is "accepted" unless stalled:
//   - shift <= {bit, shift[7:1]}; bitCount++; dataLast <= dataSync; bcInAck <= ^dataSync.
// - toggle==2'b11: error <= 1 (sticky until reset); dataLast <= dataSync; no bit shifted; ack unchanged.
// - Byte completion, when bitCount==7 and a bit is accepted:
//   - bcOut.data <= {bit, shift[7:1]}; bcOut.valid <= 1; bitCount <= 0.
// - Stall: the 8th bit is not accepted while bcOut.valid && !bcOutReady.
//   - dataLast and bcInAck hold, so the source waits. The bit is accepted the first cycle the slot frees.
// - Simultaneous events: bcOutReady in the same cycle as the 8th bit with valid=1 frees the slot.
//   - The new byte loads the same cycle, valid stays 1 (no bubble).
// - Output handshake: transfer when valid && ready. valid drops the cycle after transfer unless a new byte loads.
//   - data is stable while valid && !ready.
// - Latency: ack flips SyncCycles+1 clocks after the input edge.
//   - bcOut.valid rises SyncCycles+1 clocks after the 8th-bit edge (no stall).
// - Throughput: 1 bit per source round trip. Sink-side minimum is SyncCycles+1 clocks per bit.
// - Widths: bitCount is 3 bits and wraps 7->0 only on byte completion.
// - Timeout counter (when enabled) is $clog2(TimeoutCycles+1) bits and saturates.
// CONFIGURATION
// - OCLIB_BC_ASYNC_1B_SINK_TIMEOUT_EN defined:
//   - Idle counter clears on every accepted bit and whenever bitCount==0.
//   - It counts while bitCount!=0 and no bit is accepted.
//   - On reaching TimeoutCycles: bitCount <= 0, shift <= 0. Ack and dataLast are unchanged. error is not set.
// - OCLIB_BC_ASYNC_1B_SINK_TIMEOUT_EN undefined:
//   - No counter. Partial bytes persist indefinitely. TimeoutCycles is ignored.
// TESTING
// - Reset, idle 50 cycles -> bcInAck=0, bcOut.valid=0, error=0 throughout.
// - Send 0xA5 LSB-first (bits 1,0,1,0,0,1,0,1), ready=1:
//   - bcOut.data=8'hA5, valid for 1 cycle.
//   - ack==data0^data1 after each bit.
//   - valid rises SyncCycles+1 clocks after the last edge.
// - Send 0x3C then 0xC3 with ready=0:
//   - 0x3C holds on bcOut; ack stalls on the 8th bit of 0xC3.
//   - Raise ready -> 0x3C then 0xC3 delivered in order, no loss.
// - Force data 2'b00->2'b11 in one step -> error=1 and stays 1. No byte emitted. Ack unchanged.
// - Send 3 bits, assert reset 1 cycle, then send 0x81 -> bcOut.data=8'h81 (partial bits discarded).
// - With _TIMEOUT_EN and TimeoutCycles=16:
//   - Send 3 bits, idle 20 cycles, send 0x55 -> bcOut.data=8'h55.
//   - Without the macro the same stimulus yields a byte mixing the 3 stale bits with the first 5 bits of 0x55.

Source files
------------

// File: rtl/oclib_bc_async_1b_sink.sv
// Receiver for the two-wire toggle-coded async bit channel: synchronizes, decodes LSB-first bytes, acks each bit.
// Define OCLIB_BC_ASYNC_1B_SINK_TIMEOUT_EN to discard partial bytes after TimeoutCycles idle cycles.
module oclib_bc_async_1b_sink #(
    parameter int SyncCycles    = 3,
    parameter int TimeoutCycles = 1024
) (
    input  logic       clock,
    input  logic       reset,
    input  logic [1:0] bcIn,
    output logic       bcInAck,
    output logic [8:0] bcOut,
    input  logic       bcOutReady,
    output logic       error
);

    logic [1:0] r_sync [SyncCycles];
    logic [1:0] r_data_last;
    logic [7:0] r_shift;
    logic [2:0] r_bit_count;
    logic       r_ack;
    logic [7:0] r_out_data;
    logic       r_out_valid;
    logic       r_error;

    logic [1:0] w_data_sync;
    logic [1:0] w_toggle;
    logic       w_is_bit;
    logic       w_last_bit;
    logic       w_slot_busy;
    logic       w_accept;
    logic [7:0] w_shift_next;
    logic       w_timeout_hit;

    // bcIn is asynchronous, so it lands directly on the first flop of the chain.
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clock) begin
        if (reset) begin
            for (int i = 0; i < SyncCycles; i++) r_sync[i] <= 2'b00;
        end else begin
            r_sync[0] <= bcIn;
            for (int i = 1; i < SyncCycles; i++) r_sync[i] <= r_sync[i-1];
        end
    end

    assign w_data_sync  = r_sync[SyncCycles-1];
    assign w_toggle     = w_data_sync ^ r_data_last;
    assign w_is_bit     = w_toggle[0] ^ w_toggle[1];
    assign w_last_bit   = (r_bit_count == 3'd7);
    assign w_slot_busy  = r_out_valid && !bcOutReady;
    // The 8th bit waits for a free output slot; leaving dataLast untouched keeps the ack (and source) parked.
    assign w_accept     = w_is_bit && !(w_last_bit && w_slot_busy);
    assign w_shift_next = {w_toggle[1], r_shift[7:1]};

`ifdef OCLIB_BC_ASYNC_1B_SINK_TIMEOUT_EN
    localparam int                    IdleWidth = $clog2(TimeoutCycles + 1);
    localparam logic [IdleWidth-1:0]  IdleMax   = IdleWidth'(TimeoutCycles);

    logic [IdleWidth-1:0] r_idle;

    always_ff @(posedge clock) begin
        if (reset || w_accept || r_bit_count == 3'd0) begin
            r_idle <= '0;
        end else if (r_idle != IdleMax) begin
            r_idle <= r_idle + 1'b1;
        end
    end

    assign w_timeout_hit = (r_idle == IdleMax) && !w_accept;
`else
    logic w_unused_timeout;

    assign w_unused_timeout = ^TimeoutCycles;
    assign w_timeout_hit    = 1'b0;
`endif

    always_ff @(posedge clock) begin
        if (reset) begin
            r_data_last <= 2'b00;
            r_shift     <= 8'h00;
            r_bit_count <= 3'd0;
            r_ack       <= 1'b0;
            r_error     <= 1'b0;
        end else begin
            if (w_accept) begin
                r_shift     <= w_shift_next;
                r_bit_count <= r_bit_count + 3'd1;
                r_data_last <= w_data_sync;
                r_ack       <= ^w_data_sync;
            end else if (w_toggle == 2'b11) begin
                r_error     <= 1'b1;
                r_data_last <= w_data_sync;
            end
            if (w_timeout_hit) begin
                r_shift     <= 8'h00;
                r_bit_count <= 3'd0;
            end
        end
    end

    // A byte loading in the same cycle as a downstream transfer keeps valid high with no bubble.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_out_data  <= 8'h00;
            r_out_valid <= 1'b0;
        end else if (w_accept && w_last_bit) begin
            r_out_data  <= w_shift_next;
            r_out_valid <= 1'b1;
        end else if (bcOutReady) begin
            r_out_valid <= 1'b0;
        end
    end

    assign bcInAck = r_ack;
    assign bcOut   = {r_out_data, r_out_valid};
    assign error   = r_error;

endmodule

// File: tb/tb_oclib_bc_async_1b_sink.sv
// Directed bench for oclib_bc_async_1b_sink: a bench-side toggle source drives bytes, a scoreboard checks delivery.
module tb_oclib_bc_async_1b_sink;

    localparam int SyncCycles    = 3;
    localparam int TimeoutCycles = 16;

    logic       clk = 1'b0;
    logic       reset;
    logic [1:0] src;
    logic       ack;
    logic [8:0] bc_out;
    logic       ready;
    logic       err;

    always #5 clk = ~clk;

    oclib_bc_async_1b_sink #(
        .SyncCycles    (SyncCycles),
        .TimeoutCycles (TimeoutCycles)
    ) u_dut (
        .clock      (clk),
        .reset      (reset),
        .bcIn       (src),
        .bcInAck    (ack),
        .bcOut      (bc_out),
        .bcOutReady (ready),
        .error      (err)
    );

    int         n_vec = 0;
    int         n_err = 0;
    logic [7:0] exp_q [$];
    logic [7:0] mon_exp;
    logic       pre_valid;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_ack();
        int n;
        n = 0;
        while (ack !== ^src && n < 64) begin
            tick();
            n++;
        end
        check("ack_follows_data", 32'(ack), 32'(^src));
    endtask

    // mode 0: wait (bounded) for the ack; mode 1: check exact ack latency; mode 2: drive only.
    task automatic send_bit(input logic b, input int mode);
        logic old_ack;
        old_ack = ack;
        src[b]  = ~src[b];
        if (mode == 1) begin
            repeat (SyncCycles) tick();
            check("ack_not_early", 32'(ack), 32'(old_ack));
            pre_valid = bc_out[0];
            tick();
            check("ack_latency", 32'(ack), 32'(^src));
        end else if (mode == 0) begin
            wait_ack();
        end
    endtask

    task automatic send_byte(input logic [7:0] v, input int mode);
        for (int i = 0; i < 8; i++) send_bit(v[i], mode);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        src   = 2'b00;
        repeat (2) tick();
        reset = 1'b0;
        tick();
        check("rst_ack", 32'(ack), 32'd0);
        check("rst_valid", 32'(bc_out[0]), 32'd0);
        check("rst_error", 32'(err), 32'd0);
    endtask

    // Scoreboard: every transfer (valid && ready) must match the oldest expected byte.
    always @(negedge clk) begin
        if (!reset && bc_out[0] && ready) begin
            check("byte_expected", 32'(exp_q.size() != 0), 32'd1);
            if (exp_q.size() != 0) begin
                mon_exp = exp_q.pop_front();
                check("byte_data", 32'(bc_out[8:1]), 32'(mon_exp));
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: observed no finish expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [7:0] c3;
        logic       held_ack;

        reset = 1'b1;
        src   = 2'b00;
        ready = 1'b1;
        repeat (3) tick();
        reset = 1'b0;
        check("rst_data", 32'(bc_out[8:1]), 32'd0);
        check("rst_valid0", 32'(bc_out[0]), 32'd0);
        check("rst_ack0", 32'(ack), 32'd0);
        check("rst_err0", 32'(err), 32'd0);

        repeat (50) begin
            tick();
            check("idle_ack", 32'(ack), 32'd0);
            check("idle_valid", 32'(bc_out[0]), 32'd0);
            check("idle_err", 32'(err), 32'd0);
        end

        // 0xA5 with exact latency checks on every bit and on valid.
        exp_q.push_back(8'hA5);
        send_byte(8'hA5, 1);
        check("valid_not_early", 32'(pre_valid), 32'd0);
        check("valid_rise", 32'(bc_out[0]), 32'd1);
        check("data_a5", 32'(bc_out[8:1]), 32'hA5);
        tick();
        check("valid_one_cycle", 32'(bc_out[0]), 32'd0);

        // Back-pressure: 0x3C holds, the 8th bit of 0xC3 stalls.
        ready = 1'b0;
        exp_q.push_back(8'h3C);
        send_byte(8'h3C, 0);
        repeat (5) tick();
        check("hold_valid", 32'(bc_out[0]), 32'd1);
        check("hold_data", 32'(bc_out[8:1]), 32'h3C);
        c3 = 8'hC3;
        exp_q.push_back(c3);
        for (int i = 0; i < 7; i++) send_bit(c3[i], 0);
        held_ack = ack;
        send_bit(c3[7], 2);
        repeat (20) tick();
        check("ack_stalled", 32'(ack), 32'(held_ack));
        check("stall_data", 32'(bc_out[8:1]), 32'h3C);
        check("stall_valid", 32'(bc_out[0]), 32'd1);
        ready = 1'b1;
        tick();
        check("no_bubble_valid", 32'(bc_out[0]), 32'd1);
        check("no_bubble_data", 32'(bc_out[8:1]), 32'hC3);
        wait_ack();
        repeat (5) tick();
        check("stall_drained", 32'(exp_q.size()), 32'd0);

        // Both wires toggling at once is a sticky protocol error.
        do_reset();
        src = 2'b11;
        repeat (10) tick();
        check("err_set", 32'(err), 32'd1);
        check("err_ack", 32'(ack), 32'd0);
        check("err_no_byte", 32'(bc_out[0]), 32'd0);
        repeat (20) tick();
        check("err_sticky", 32'(err), 32'd1);

        // Reset mid-byte drops the partial bits.
        do_reset();
        send_bit(1'b1, 0);
        send_bit(1'b0, 0);
        send_bit(1'b1, 0);
        reset = 1'b1;
        src   = 2'b00;
        tick();
        reset = 1'b0;
        exp_q.push_back(8'h81);
        send_byte(8'h81, 0);
        repeat (5) tick();
        check("rst_mid_drained", 32'(exp_q.size()), 32'd0);

        // Partial byte followed by a long idle, then 0x55.
        do_reset();
        send_bit(1'b1, 0);
        send_bit(1'b1, 0);
        send_bit(1'b0, 0);
        repeat (20) tick();
`ifdef OCLIB_BC_ASYNC_1B_SINK_TIMEOUT_EN
        exp_q.push_back(8'h55);
`else
        exp_q.push_back(8'hAB);
`endif
        send_byte(8'h55, 0);
        repeat (5) tick();
        check("timeout_drained", 32'(exp_q.size()), 32'd0);
        check("timeout_no_err", 32'(err), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
